// File: rtl/booth_multiplier_param.sv
// booth_multiplier_param
// Signed (two's complement) sequential Booth multiplier with serial operand
// loading and a two-beat product readout.
//
// Optional build macro: BOOTH_RADIX4_EN
//   undefined : radix-2 Booth, WIDTH iterations in CALC
//   defined   : modified Booth radix-4, WIDTH/2 iterations in CALC
// Both builds produce bit-identical products; only the CALC latency differs.
//
// Parameters:
//   WIDTH    operand width in bits (even, >= 4)
//   CNT_W    iteration counter width
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start     begin an operation (sampled only in IDLE)
//   data_in   operand bus: multiplicand in LOAD_X, multiplier in LOAD_Y
//   data_out  product beat: low half in OUT_LO, high half in OUT_HI, else 0
//   done      high while data_out carries a valid product beat
//   busy      high in every state except IDLE
module booth_multiplier_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             done,
  output logic             busy
);

`ifdef BOOTH_RADIX4_EN
  // One extra guard bit so that +/-2X fits in the accumulator.
  localparam int AW = WIDTH + 3;
  localparam int N  = WIDTH / 2;
`else
  localparam int AW = WIDTH + 2;
  localparam int N  = WIDTH;
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    LOAD_Y,
    CALC,
    OUT_LO,
    OUT_HI
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] y_reg;
  logic [AW-1:0]    a_reg;
  logic             q_reg;
  logic [CNT_W-1:0] cnt;

  logic [AW-1:0]    x_ext;
  logic [AW-1:0]    a_sum;
  logic [AW-1:0]    a_next;
  logic [WIDTH-1:0] y_next;
  logic             q_next;

  assign x_ext = {{(AW-WIDTH){x_reg[WIDTH-1]}}, x_reg};

`ifdef BOOTH_RADIX4_EN
  logic [AW-1:0] x_dbl;

  assign x_dbl = {x_ext[AW-2:0], 1'b0};

  // One radix-4 Booth step: recode {Y[1],Y[0],q(-1)} into 0, +/-X or +/-2X,
  // accumulate, then arithmetic-shift the {A,Y,q} chain right by two.
  always_comb begin
    a_sum = a_reg;
    case ({y_reg[1:0], q_reg})
      3'b001, 3'b010: a_sum = a_reg + x_ext;
      3'b011:         a_sum = a_reg + x_dbl;
      3'b100:         a_sum = a_reg - x_dbl;
      3'b101, 3'b110: a_sum = a_reg - x_ext;
      default:        a_sum = a_reg;
    endcase
    a_next = {{2{a_sum[AW-1]}}, a_sum[AW-1:2]};
    y_next = {a_sum[1:0], y_reg[WIDTH-1:2]};
    q_next = y_reg[1];
  end
`else
  // One radix-2 Booth step: {Y[0],q(-1)} = 01 adds X, 10 subtracts X,
  // then the {A,Y,q} chain is arithmetic-shifted right by one.
  always_comb begin
    a_sum = a_reg;
    case ({y_reg[0], q_reg})
      2'b01:   a_sum = a_reg + x_ext;
      2'b10:   a_sum = a_reg - x_ext;
      default: a_sum = a_reg;
    endcase
    a_next = {a_sum[AW-1], a_sum[AW-1:1]};
    y_next = {a_sum[0], y_reg[WIDTH-1:1]};
    q_next = y_reg[0];
  end
`endif

  // Control FSM and datapath registers. Outputs are registered; data_out and
  // done default to zero and are only driven while a product beat is valid.
  // After the last iteration the product sits in {A[WIDTH-1:0], Y}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      x_reg    <= '0;
      y_reg    <= '0;
      a_reg    <= '0;
      q_reg    <= 1'b0;
      cnt      <= '0;
      data_out <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      data_out <= '0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD_X;
            busy  <= 1'b1;
          end
        end
        LOAD_X: begin
          x_reg <= data_in;
          state <= LOAD_Y;
        end
        LOAD_Y: begin
          y_reg <= data_in;
          a_reg <= '0;
          q_reg <= 1'b0;
          cnt   <= CNT_W'(N);
          state <= CALC;
        end
        CALC: begin
          if (cnt != '0) begin
            a_reg <= a_next;
            y_reg <= y_next;
            q_reg <= q_next;
            cnt   <= cnt - CNT_W'(1);
          end else begin
            data_out <= y_reg;
            done     <= 1'b1;
            state    <= OUT_LO;
          end
        end
        OUT_LO: begin
          data_out <= a_reg[WIDTH-1:0];
          done     <= 1'b1;
          state    <= OUT_HI;
        end
        OUT_HI: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_multiplier_param.sv
// tb_booth_multiplier_param
// Self-checking bench for booth_multiplier_param (WIDTH=8). Expected products
// come from plain signed integer multiplication; expected latencies come from
// the operation timeline (low beat N+3 edges after the start edge).
module tb_booth_multiplier_param;

  localparam int WIDTH = 8;
`ifdef BOOTH_RADIX4_EN
  localparam int N = WIDTH / 2;
`else
  localparam int N = WIDTH;
`endif
  localparam int MAX_WAIT = 40;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             done;
  logic             busy;

  int checks;
  int passed;

  booth_multiplier_param #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (data_in),
    .data_out (data_out),
    .done     (done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-width signed product.
  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = $signed(a) * $signed(b);
    return 16'(p);
  endfunction

  // Advance past the next rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one full operation from IDLE and report what was observed.
  // lat is the edge count from the start edge to the first done (-1 on timeout).
  task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                        output int lat, output logic [7:0] lo, output logic [7:0] hi,
                        output logic done_hi, output logic done_after,
                        output logic busy_after);
    start   = 1'b1;
    data_in = x;
    step();
    start = 1'b0;
    step();
    data_in = y;
    step();
    data_in = 8'($urandom);
    lat = -1;
    for (int e = 3; e < MAX_WAIT; e++) begin
      step();
      if (done) begin
        lat = e;
        break;
      end
    end
    lo = data_out;
    step();
    hi      = data_out;
    done_hi = done;
    step();
    done_after = done;
    busy_after = busy;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    step();
    step();
    checks++;
    if (data_out !== 8'h00) $display("[TB] FAIL reset_data_out: got %h expected 00", data_out);
    else passed++;
    checks++;
    if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_directed();
    logic [7:0]  xs[5];
    logic [7:0]  ys[5];
    logic [15:0] ps[5];
    int lat;
    logic [7:0] lo, hi;
    logic dh, da, ba;
    xs = '{8'h03, 8'hFD, 8'h80, 8'h7F, 8'hFF};
    ys = '{8'h05, 8'h05, 8'h80, 8'h80, 8'hFF};
    ps = '{16'h000F, 16'hFFF1, 16'h4000, 16'hC080, 16'h0001};
    for (int i = 0; i < 5; i++) begin
      run_op(xs[i], ys[i], lat, lo, hi, dh, da, ba);
      checks++;
      if (lat != N + 3) $display("[TB] FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, N + 3);
      else passed++;
      checks++;
      if (lo !== ps[i][7:0]) $display("[TB] FAIL directed_lo[%0d]: got %h expected %h", i, lo, ps[i][7:0]);
      else passed++;
      checks++;
      if (hi !== ps[i][15:8]) $display("[TB] FAIL directed_hi[%0d]: got %h expected %h", i, hi, ps[i][15:8]);
      else passed++;
      checks++;
      if (dh !== 1'b1 || da !== 1'b0 || ba !== 1'b0)
        $display("[TB] FAIL directed_done_busy[%0d]: got done_hi=%b done_after=%b busy_after=%b expected 1 0 0",
                 i, dh, da, ba);
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [7:0]  x, y;
    logic [15:0] p;
    int lat;
    logic [7:0] lo, hi;
    logic dh, da, ba;
    for (int i = 0; i < 24; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      p = ref_mul(x, y);
      run_op(x, y, lat, lo, hi, dh, da, ba);
      checks++;
      if (lat != N + 3 || lo !== p[7:0] || hi !== p[15:8] || dh !== 1'b1 || ba !== 1'b0)
        $display("[TB] FAIL random_op %h*%h: got lat=%0d prod=%h%h expected lat=%0d prod=%h",
                 x, y, lat, hi, lo, N + 3, p);
      else passed++;
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0]  x, y, lo, hi;
    logic [15:0] p;
    logic busy_ok, dh, da, ba;
    int lat;
    x = 8'h93;
    y = 8'h2D;
    p = ref_mul(x, y);
    start   = 1'b1;
    data_in = x;
    step();
    start = 1'b0;
    step();
    data_in = y;
    step();
    busy_ok = busy;
    lat = -1;
    for (int e = 3; e < MAX_WAIT; e++) begin
      if (e == 4 || e == 5) begin
        start   = 1'b1;
        data_in = 8'h02;
      end else begin
        start = 1'b0;
      end
      step();
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = e;
        break;
      end
    end
    start = 1'b0;
    lo = data_out;
    step();
    if (!busy) busy_ok = 1'b0;
    hi = data_out;
    step();
    checks++;
    if (lat != N + 3) $display("[TB] FAIL ignore_latency: got %0d expected %0d", lat, N + 3);
    else passed++;
    checks++;
    if ({hi, lo} !== p) $display("[TB] FAIL ignore_product: got %h expected %h", {hi, lo}, p);
    else passed++;
    checks++;
    if (busy_ok !== 1'b1) $display("[TB] FAIL ignore_busy_held: got %b expected 1", busy_ok);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL ignore_idle_after: got busy=%b expected 0", busy);
    else passed++;
    run_op(8'h02, 8'h02, lat, lo, hi, dh, da, ba);
    checks++;
    if (lo !== 8'h04 || hi !== 8'h00 || lat != N + 3)
      $display("[TB] FAIL ignore_next_op: got lat=%0d prod=%h%h expected lat=%0d prod=0004", lat, hi, lo, N + 3);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int lat;
    logic seen_done;
    logic [7:0] lo, hi;
    logic dh, da, ba;
    // Reset in the middle of CALC.
    start   = 1'b1;
    data_in = 8'h55;
    step();
    start = 1'b0;
    step();
    data_in = 8'h33;
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || data_out !== 8'h00)
      $display("[TB] FAIL reset_mid_calc: got busy=%b done=%b data_out=%h expected 0 0 00", busy, done, data_out);
    else passed++;
    step();
    rst = 1'b0;
    seen_done = 1'b0;
    for (int e = 0; e < 20; e++) begin
      step();
      if (done || busy) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) $display("[TB] FAIL reset_no_late_done: got activity=%b expected 0", seen_done);
    else passed++;

    // Reset while a product beat is on the bus.
    start   = 1'b1;
    data_in = 8'h7F;
    step();
    start = 1'b0;
    step();
    data_in = 8'h7F;
    step();
    lat = -1;
    for (int e = 3; e < MAX_WAIT; e++) begin
      step();
      if (done) begin
        lat = e;
        break;
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (lat < 0 || data_out !== 8'h00 || done !== 1'b0)
      $display("[TB] FAIL reset_mid_out: got lat=%0d done=%b data_out=%h expected done=0 data_out=00", lat, done, data_out);
    else passed++;
    step();
    rst = 1'b0;
    step();

    run_op(8'hFF, 8'hFF, lat, lo, hi, dh, da, ba);
    checks++;
    if (lo !== 8'h01 || hi !== 8'h00 || lat != N + 3)
      $display("[TB] FAIL reset_next_op: got lat=%0d prod=%h%h expected lat=%0d prod=0001", lat, hi, lo, N + 3);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    logic [7:0] lo1, hi1, lo2, hi2;
    logic gap_busy;
    start   = 1'b1;
    data_in = 8'h07;
    step();
    step();
    data_in = 8'h06;
    step();
    data_in = 8'($urandom);
    lat1 = -1;
    for (int e = 3; e < MAX_WAIT; e++) begin
      step();
      if (done) begin
        lat1 = e;
        break;
      end
    end
    lo1 = data_out;
    step();
    hi1 = data_out;
    data_in = 8'hFF;
    step();
    gap_busy = busy;
    step();
    step();
    start   = 1'b0;
    data_in = 8'h01;
    step();
    data_in = 8'($urandom);
    lat2 = -1;
    for (int e = 5; e < MAX_WAIT; e++) begin
      step();
      if (done) begin
        lat2 = e;
        break;
      end
    end
    lo2 = data_out;
    step();
    hi2 = data_out;
    step();
    checks++;
    if (lat1 != N + 3 || lo1 !== 8'h2A || hi1 !== 8'h00)
      $display("[TB] FAIL b2b_first: got lat=%0d prod=%h%h expected lat=%0d prod=002A", lat1, hi1, lo1, N + 3);
    else passed++;
    checks++;
    if (gap_busy !== 1'b0) $display("[TB] FAIL b2b_idle_gap: got busy=%b expected 0", gap_busy);
    else passed++;
    checks++;
    if (lat2 != N + 5) $display("[TB] FAIL b2b_second_latency: got %0d expected %0d", lat2, N + 5);
    else passed++;
    checks++;
    if (lo2 !== 8'hFF || hi2 !== 8'hFF)
      $display("[TB] FAIL b2b_second: got %h%h expected FFFF", hi2, lo2);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL b2b_idle_end: got busy=%b expected 0", busy);
    else passed++;
  endtask

  initial begin
    checks  = 0;
    passed  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
